writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_if.sv | 19 +
 rtl/writeback_queue.sv | 77 +++++++
 tb/tb_writeback_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// writeback_queue_if: producer and register-file handshake signals for writeback_queue
interface writeback_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rd;
    logic [15:0] in_data;
    logic        wb_stall;
    logic        writeEnable;
    logic [2:0]  writeRpoint;
    logic [15:0] writeData;
    modport master (
        output in_valid, in_rd, in_data, wb_stall,
        input  in_ready, writeEnable, writeRpoint, writeData
    );
    modport slave (
        input  in_valid, in_rd, in_data, wb_stall,
        output in_ready, writeEnable, writeRpoint, writeData
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: circular FIFO of pending register writes; define WB_BYPASS_EN to compile in forward lookup
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_queue_if.slave  wb,
    input  logic [2:0]        rs1,
    input  logic [2:0]        rs2,
    output logic              fwd1_hit,
    output logic [15:0]       fwd1_data,
    output logic              fwd2_hit,
    output logic [15:0]       fwd2_data,
    output logic [4:0]        count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [2:0]    rd_q   [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;
    assign wb.in_ready    = count != 5'(DEPTH);
    assign push           = wb.in_valid && wb.in_ready && wb.in_rd != 3'd0;
    assign wb.writeEnable = count != 5'd0 && !wb.wb_stall;
    assign pop            = wb.writeEnable;
    assign wb.writeRpoint = count != 5'd0 ? rd_q[head] : 3'd0;
    assign wb.writeData   = count != 5'd0 ? data_q[head] : 16'd0;
    // pointers and occupancy; entry validity is derived from count, so clearing it invalidates everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 5'd0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + 5'(push) - 5'(pop);
        end
    end
    // entry payload storage, written at the tail on accept
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail]   <= wb.in_rd;
            data_q[tail] <= wb.in_data;
        end
    end
`ifdef WB_BYPASS_EN
    logic [AW-1:0] idx;
    // scan oldest to youngest so the youngest matching entry's value wins
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = 16'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 16'd0;
        idx       = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (5'(i) < count && rs1 != 3'd0 && rd_q[idx] == rs1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = data_q[idx];
            end
            if (5'(i) < count && rs2 != 3'd0 && rd_q[idx] == rs2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = data_q[idx];
            end
        end
    end
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = 16'd0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = 16'd0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed stimulus with a scoreboard of expected register-file writes
module tb_writeback_queue;
    logic        clk;
    logic        rst_n;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        fwd1_hit;
    logic [15:0] fwd1_data;
    logic        fwd2_hit;
    logic [15:0] fwd2_data;
    logic [4:0]  count;
    int          total;
    int          bad;
    logic [18:0] exp_q[$];
    logic [18:0] e;
    writeback_queue_if wb();
    writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb), .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data), .count(count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    // offer one entry; rdy is the in_ready this bench expects, an accepted nonzero rd is scoreboarded
    task automatic offer(input logic [2:0] rd, input logic [15:0] d, input logic rdy);
        wb.in_valid = 1'b1;
        wb.in_rd    = rd;
        wb.in_data  = d;
        #1 chk("in_ready", int'(wb.in_ready), int'(rdy));
        @(posedge clk);
        #1;
        wb.in_valid = 1'b0;
        if (rdy && rd != 3'd0) exp_q.push_back({rd, d});
    endtask
    task automatic fwd_chk(input logic h1, input logic [15:0] d1, input logic h2, input logic [15:0] d2);
`ifdef WB_BYPASS_EN
        chk("fwd1_hit", int'(fwd1_hit), int'(h1));
        chk("fwd1_data", int'(fwd1_data), int'(d1));
        chk("fwd2_hit", int'(fwd2_hit), int'(h2));
        chk("fwd2_data", int'(fwd2_data), int'(d2));
`else
        chk("fwd1_hit", int'(fwd1_hit), 0);
        chk("fwd1_data", int'(fwd1_data), 0);
        chk("fwd2_hit", int'(fwd2_hit), 0);
        chk("fwd2_data", int'(fwd2_data), 0);
        if (h1 || h2 || d1 != 16'd0 || d2 != 16'd0) begin end
`endif
    endtask
    // monitor: every register-file write must match the oldest outstanding accepted entry
    always @(negedge clk) begin
        if (wb.writeEnable) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", wb.writeRpoint, wb.writeData);
            end else begin
                e = exp_q.pop_front();
                chk("write_rd", int'(wb.writeRpoint), int'(e[18:16]));
                chk("write_data", int'(wb.writeData), int'(e[15:0]));
            end
        end
    end
    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        wb.in_valid = 1'b0;
        wb.in_rd    = 3'd0;
        wb.in_data  = 16'd0;
        wb.wb_stall = 1'b0;
        rs1         = 3'd3;
        rs2         = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(wb.in_ready), 1);
        chk("rst_we", int'(wb.writeEnable), 0);
        chk("rst_rpoint", int'(wb.writeRpoint), 0);
        chk("rst_wdata", int'(wb.writeData), 0);
        chk("rst_count", int'(count), 0);
        fwd_chk(1'b0, 16'd0, 1'b0, 16'd0);
        rst_n = 1'b1;
        rs1   = 3'd0;
        rs2   = 3'd0;
        @(posedge clk);
        #1;
        offer(3'd3, 16'h1234, 1'b1);
        chk("single_count", int'(count), 1);
        chk("single_we", int'(wb.writeEnable), 1);
        chk("single_rpoint", int'(wb.writeRpoint), 3);
        chk("single_wdata", int'(wb.writeData), 16'h1234);
        @(posedge clk);
        #1;
        chk("single_drained", int'(count), 0);
        wb.wb_stall = 1'b1;
        offer(3'd1, 16'h0011, 1'b1);
        offer(3'd2, 16'h0022, 1'b1);
        offer(3'd3, 16'h0033, 1'b1);
        offer(3'd4, 16'h0044, 1'b1);
        chk("full_count", int'(count), 4);
        chk("full_we", int'(wb.writeEnable), 0);
        offer(3'd5, 16'h0055, 1'b0);
        chk("full_reject_count", int'(count), 4);
        wb.wb_stall = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("full_drained", int'(count), 0);
        offer(3'd0, 16'hFFFF, 1'b1);
        chk("rd0_count", int'(count), 0);
        chk("rd0_we", int'(wb.writeEnable), 0);
        repeat (2) @(posedge clk);
        #1;
        wb.wb_stall = 1'b1;
        offer(3'd5, 16'h00AA, 1'b1);
        offer(3'd5, 16'h00BB, 1'b1);
        rs1 = 3'd5;
        rs2 = 3'd6;
        #1 fwd_chk(1'b1, 16'h00BB, 1'b0, 16'd0);
        wb.in_valid = 1'b1;
        wb.in_rd    = 3'd6;
        wb.in_data  = 16'h0066;
        #1 fwd_chk(1'b1, 16'h00BB, 1'b0, 16'd0);
        wb.in_valid = 1'b0;
        wb.wb_stall = 1'b0;
        #1 fwd_chk(1'b1, 16'h00BB, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        chk("bypass_last_count", int'(count), 1);
        fwd_chk(1'b1, 16'h00BB, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        chk("bypass_drained", int'(count), 0);
        fwd_chk(1'b0, 16'd0, 1'b0, 16'd0);
        rs1 = 3'd0;
        rs2 = 3'd0;
        wb.wb_stall = 1'b1;
        offer(3'd1, 16'h0101, 1'b1);
        offer(3'd2, 16'h0202, 1'b1);
        offer(3'd3, 16'h0303, 1'b1);
        chk("pre_reset_count", int'(count), 3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_we", int'(wb.writeEnable), 0);
        chk("async_rst_ready", int'(wb.in_ready), 1);
        wb.wb_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        offer(3'd6, 16'h0606, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_drained", int'(count), 0);
        for (int i = 0; i < 10; i++) offer(3'((i % 7) + 1), 16'(i), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("stream_drained", int'(count), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
